// File: rtl/axi_lite_slave_regs_if.sv
// AXI-Lite bus bundle for the register slave.
//   master modport: drives AW/W/AR channels and BREADY/RREADY.
//   slave  modport: drives the READY flags and the B/R responses.
interface axi_lite_slave_regs_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite slave exposing NUM_REGS 32-bit read/write registers.
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   bus           : AXI-Lite slave side (AW/W/B write path, AR/R read path)
//   reg_q         : register contents, reg k at [32k+31:32k]
//   reg_wr_pulse  : one-cycle strobe per committed in-range write, bit k = reg k
// Write and read paths run independently, one outstanding transaction each.
// Every output is registered.
module axi_lite_slave_regs #(
   parameter int          ADDR_W    = 8,
   parameter int          NUM_REGS  = 16,
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   axi_lite_slave_regs_if.slave     bus,
   output logic [NUM_REGS*32-1:0]   reg_q,
   output logic [NUM_REGS-1:0]      reg_wr_pulse
);
   localparam int             IDX_W   = ADDR_W - 2;
   // one extra bit so NUM_REGS == 2**IDX_W still compares correctly
   localparam logic [IDX_W:0] IDX_LIM = (IDX_W + 1)'(NUM_REGS);
   localparam logic [1:0]     OKAY    = 2'b00;
   localparam logic [1:0]     SLVERR  = 2'b10;

   typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_DATA}    rd_state_t;

   wr_state_t wr_state, wr_state_d;
   rd_state_t rd_state, rd_state_d;

   logic [NUM_REGS-1:0][31:0] regs;

   logic              aw_held, aw_held_d, w_held, w_held_d;
   logic [IDX_W-1:0]  aw_idx, aw_idx_d;
   logic [31:0]       w_data, w_data_d;
   logic [3:0]        w_strb, w_strb_d;
   logic              awready_d, wready_d, bvalid_d;
   logic [1:0]        bresp_d;
   logic              wr_ok;
   logic [NUM_REGS-1:0] wr_hit;

   logic [IDX_W-1:0]  ar_idx;
   logic [31:0]       rd_mux;
   logic              rd_ok;
   logic              arready_d, rvalid_d;
   logic [31:0]       rdata_d;
   logic [1:0]        rresp_d;

   assign reg_q  = regs;
   assign wr_ok  = {1'b0, aw_idx} < IDX_LIM;
   assign ar_idx = bus.araddr[ADDR_W-1:2];
   assign rd_ok  = {1'b0, ar_idx} < IDX_LIM;

   // ---------------- write path ----------------
   always_comb begin
      wr_state_d = wr_state;
      aw_held_d  = aw_held;
      w_held_d   = w_held;
      aw_idx_d   = aw_idx;
      w_data_d   = w_data;
      w_strb_d   = w_strb;
      awready_d  = bus.awready;
      wready_d   = bus.wready;
      bvalid_d   = bus.bvalid;
      bresp_d    = bus.bresp;
      wr_hit     = '0;
      case (wr_state)
         WR_COLLECT: begin
            if (aw_held && w_held) begin
               // both halves present: commit this edge, answer on B
               for (int k = 0; k < NUM_REGS; k++)
                  wr_hit[k] = wr_ok && (aw_idx == IDX_W'(k));
               bvalid_d   = 1'b1;
               bresp_d    = wr_ok ? OKAY : SLVERR;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               awready_d  = 1'b0;
               wready_d   = 1'b0;
               wr_state_d = WR_RESP;
            end else begin
               if (bus.awvalid && bus.awready) begin
                  aw_held_d = 1'b1;
                  aw_idx_d  = bus.awaddr[ADDR_W-1:2];
               end
               if (bus.wvalid && bus.wready) begin
                  w_held_d = 1'b1;
                  w_data_d = bus.wdata;
                  w_strb_d = bus.wstrb;
               end
               // READY drops the cycle after its own handshake
               awready_d = !aw_held_d;
               wready_d  = !w_held_d;
            end
         end
         WR_RESP: begin
            if (bus.bready) begin
               bvalid_d   = 1'b0;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
               wr_state_d = WR_COLLECT;
            end
         end
         default: wr_state_d = WR_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state     <= WR_COLLECT;
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_idx       <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         bus.awready  <= 1'b0;
         bus.wready   <= 1'b0;
         bus.bvalid   <= 1'b0;
         bus.bresp    <= OKAY;
         reg_wr_pulse <= '0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
      end else begin
         wr_state     <= wr_state_d;
         aw_held      <= aw_held_d;
         w_held       <= w_held_d;
         aw_idx       <= aw_idx_d;
         w_data       <= w_data_d;
         w_strb       <= w_strb_d;
         bus.awready  <= awready_d;
         bus.wready   <= wready_d;
         bus.bvalid   <= bvalid_d;
         bus.bresp    <= bresp_d;
         reg_wr_pulse <= wr_hit;
         for (int k = 0; k < NUM_REGS; k++)
            for (int b = 0; b < 4; b++)
               if (wr_hit[k] && w_strb[b]) regs[k][8*b +: 8] <= w_data[8*b +: 8];
      end
   end

   // ---------------- read path ----------------
   // out-of-range index matches no register, so the mux yields zero
   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < NUM_REGS; k++)
         if (ar_idx == IDX_W'(k)) rd_mux = regs[k];
   end

   always_comb begin
      rd_state_d = rd_state;
      arready_d  = bus.arready;
      rvalid_d   = bus.rvalid;
      rdata_d    = bus.rdata;
      rresp_d    = bus.rresp;
      case (rd_state)
         RD_IDLE: begin
            arready_d = 1'b1;
            if (bus.arvalid && bus.arready) begin
               // sampled from pre-edge register state: a write committing on
               // this same edge is not yet visible
               rdata_d    = rd_mux;
               rresp_d    = rd_ok ? OKAY : SLVERR;
               rvalid_d   = 1'b1;
               arready_d  = 1'b0;
               rd_state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            if (bus.rready) begin
               rvalid_d   = 1'b0;
               arready_d  = 1'b1;
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state    <= RD_IDLE;
         bus.arready <= 1'b0;
         bus.rvalid  <= 1'b0;
         bus.rdata   <= '0;
         bus.rresp   <= OKAY;
      end else begin
         rd_state    <= rd_state_d;
         bus.arready <= arready_d;
         bus.rvalid  <= rvalid_d;
         bus.rdata   <= rdata_d;
         bus.rresp   <= rresp_d;
      end
   end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
module tb_axi_lite_slave_regs;
   localparam int          ADDR_W    = 8;
   localparam int          NUM_REGS  = 16;
   localparam logic [31:0] RESET_VAL = 32'h0000_0000;
   localparam int          VW        = NUM_REGS * 32;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [VW-1:0]       reg_q;
   logic [NUM_REGS-1:0] reg_wr_pulse;

   int n_asrt = 0;
   int n_fail = 0;

   // reference: plain array of register values
   logic [31:0] model [NUM_REGS];

   axi_lite_slave_regs_if #(.ADDR_W(ADDR_W)) bus ();

   axi_lite_slave_regs #(
      .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RESET_VAL(RESET_VAL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VW-1:0] model_vec();
      logic [VW-1:0] v;
      for (int k = 0; k < NUM_REGS; k++) v[k*32 +: 32] = model[k];
      return v;
   endfunction

   // lead > 0: W presented that many cycles before AW; lead < 0: AW first
   task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int bdelay);
      int aw_at, w_at, cyc, idx;
      bit aw_done, w_done, aw_hs, w_hs;
      logic [31:0] mask;
      logic [NUM_REGS-1:0] exp_pulse;
      logic [1:0] exp_resp;
      aw_at = (lead > 0) ? lead : 0;
      w_at  = (lead < 0) ? -lead : 0;
      aw_done = 0; w_done = 0; cyc = 0;
      while (!(aw_done && w_done) && cyc < 50) begin
         bus.awaddr  = addr;
         bus.wdata   = data;
         bus.wstrb   = strb;
         bus.awvalid = !aw_done && (cyc >= aw_at);
         bus.wvalid  = !w_done && (cyc >= w_at);
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         step();
         if (aw_hs) aw_done = 1;
         if (w_hs)  w_done = 1;
         cyc++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      chk("wr_hs_timeout", aw_done && w_done, 1'b1);
      chk("b_early", bus.bvalid, 1'b0);
      step();
      idx = int'(addr[7:2]);
      if (idx < NUM_REGS) begin
         mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
         model[idx] = (model[idx] & ~mask) | (data & mask);
         exp_pulse = NUM_REGS'(1) << idx;
         exp_resp = 2'b00;
      end else begin
         exp_pulse = '0;
         exp_resp = 2'b10;
      end
      chk("bvalid", bus.bvalid, 1'b1);
      chk("bresp", bus.bresp, exp_resp);
      chk("wr_pulse", reg_wr_pulse, exp_pulse);
      chk("reg_q_wr", reg_q, model_vec());
      chk("rdy_in_resp", {bus.awready, bus.wready}, 2'b00);
      for (int i = 0; i < bdelay; i++) begin
         // a second write address waiting: it must not be taken yet
         bus.awaddr  = 8'h3C;
         bus.awvalid = 1'b1;
         step();
         chk("b_hold", {bus.bvalid, bus.bresp, bus.awready, bus.wready}, {1'b1, exp_resp, 2'b00});
         chk("pulse_once", reg_wr_pulse, '0);
      end
      bus.awvalid = 1'b0;
      bus.bready  = 1'b1;
      step();
      bus.bready  = 1'b0;
      chk("b_done", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
      chk("pulse_clr", reg_wr_pulse, '0);
   endtask

   task automatic do_read(input logic [7:0] addr, input int rdelay);
      int idx, cyc;
      bit done, hs;
      logic [31:0] exp_d;
      logic [1:0] exp_r;
      idx = int'(addr[7:2]);
      if (idx < NUM_REGS) begin
         exp_d = model[idx]; exp_r = 2'b00;
      end else begin
         exp_d = 32'h0; exp_r = 2'b10;
      end
      bus.araddr = addr;
      bus.arvalid = 1'b1;
      done = 0; cyc = 0;
      while (!done && cyc < 50) begin
         hs = bus.arready;
         step();
         if (hs) done = 1;
         cyc++;
      end
      bus.arvalid = 1'b0;
      chk("ar_timeout", done, 1'b1);
      chk("r_first", {bus.rvalid, bus.arready, bus.rresp}, {1'b1, 1'b0, exp_r});
      chk("rdata", bus.rdata, exp_d);
      for (int i = 0; i < rdelay; i++) begin
         step();
         chk("r_hold", {bus.rvalid, bus.arready, bus.rresp, bus.rdata}, {1'b1, 1'b0, exp_r, exp_d});
      end
      bus.rready = 1'b1;
      step();
      bus.rready = 1'b0;
      chk("r_done", {bus.rvalid, bus.arready}, 2'b01);
   endtask

   initial begin
      logic [31:0] old3;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) model[k] = RESET_VAL;

      // reset state and READY rise one cycle after release
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                      bus.bresp, bus.rresp}, '0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_regs", reg_q, model_vec());
      chk("rst_pulse", reg_wr_pulse, '0);
      rst_n = 1'b1;
      chk("rdy_at_release", {bus.awready, bus.wready, bus.arready}, 3'b000);
      step();
      chk("rdy_after_release", {bus.awready, bus.wready, bus.arready}, 3'b111);

      // directed cases
      do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
      chk("pulse_reg1", 16'h0002, 16'h0002 & {16{reg_q[63:32] == 32'hDEADBEEF}});
      do_write(8'h08, 32'h11223344, 4'hF, 0, 0);
      do_write(8'h08, 32'hAABBCCDD, 4'b0101, 2, 0);
      chk("reg2_merge", reg_q[95:64], 32'h11BB33DD);
      do_read(8'h04, 3);
      do_write(8'h40, 32'hCAFEF00D, 4'hF, -1, 0);
      do_read(8'h40, 1);
      do_write(8'h10, 32'h01234567, 4'hF, 0, 5);
      do_write(8'h13, 32'hFFFFFFFF, 4'h0, -2, 1);
      do_read(8'h11, 0);

      // read handshake on the same edge as the write commit sees old data
      old3 = model[3];
      bus.awaddr = 8'h0C; bus.wdata = 32'h55AA55AA; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.araddr = 8'h0C; bus.arvalid = 1'b1;
      step();
      bus.arvalid = 1'b0;
      model[3] = 32'h55AA55AA;
      chk("hz_valids", {bus.bvalid, bus.rvalid}, 2'b11);
      chk("hz_rdata_old", bus.rdata, old3);
      chk("hz_reg_new", reg_q, model_vec());
      bus.bready = 1'b1; bus.rready = 1'b1;
      step();
      bus.bready = 1'b0; bus.rready = 1'b0;
      chk("hz_done", {bus.bvalid, bus.rvalid}, 2'b00);
      do_read(8'h0C, 0);

      // randomized traffic, including out-of-range indices 16..19
      for (int it = 0; it < 40; it++) begin
         logic [7:0] a;
         a = 8'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
         do_write(a, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
         a = 8'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
         do_read(a, int'($urandom_range(0, 2)));
      end

      // reset while both B and R responses are pending
      bus.awaddr = 8'h14; bus.wdata = 32'h9999_0000; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      bus.araddr = 8'h04; bus.arvalid = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      step();
      chk("pre_rst_valids", {bus.bvalid, bus.rvalid}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NUM_REGS; k++) model[k] = RESET_VAL;
      chk("mid_rst_ctl", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                          bus.bresp, bus.rresp}, '0);
      chk("mid_rst_rdata", bus.rdata, 32'h0);
      chk("mid_rst_regs", reg_q, model_vec());
      chk("mid_rst_pulse", reg_wr_pulse, '0);
      step();
      rst_n = 1'b1;
      chk("rdy_at_release2", {bus.awready, bus.wready, bus.arready}, 3'b000);
      step();
      chk("rdy_after_release2", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid},
          5'b11100);
      do_write(8'h00, 32'h0BADF00D, 4'hF, 1, 0);
      do_read(8'h14, 0);
      chk("final_regs", reg_q, model_vec());

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
